// File: rtl/inner_prod_accum.sv
// Frame accumulator behind the 3-element inner-product unit: sums one beat per handshake into a
// wide dot product and presents one registered result per frame. Define INNER_PROD_ACC_SAT_EN for a saturating accumulator.
module inner_prod_accum #(
    parameter int IN_W      = 17,
    parameter int ACC_W     = 24,
    parameter int MAX_BEATS = 64,
    parameter int CNT_W     = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_p,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_trunc,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    state_t           state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ovf_reg, ovf_next;
    logic             accept, close;
    logic [ACC_W-1:0] in_ext;
    logic [ACC_W:0]   sum_wide;

    assign in_ext   = ACC_W'(in_p);
    assign accept   = in_valid && in_ready;
    assign sum_wide = {1'b0, acc_reg} + {1'b0, in_ext};

    // Datapath next values and the frame-close decision.
    always_comb begin
        acc_next = acc_reg;
        cnt_next = cnt_reg;
        ovf_next = ovf_reg;
        close    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    acc_next = in_ext;
                    cnt_next = CNT_W'(1);
                    ovf_next = 1'b0;
                    close    = in_last || (MAX_BEATS == 1);
                end
            end
            ACCUM: begin
                if (accept) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                    ovf_next = ovf_reg | sum_wide[ACC_W];
`ifdef INNER_PROD_ACC_SAT_EN
                    // Once clamped the frame stays clamped, even if later beats would not carry.
                    acc_next = ovf_next ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
                    acc_next = sum_wide[ACC_W-1:0];
`endif
                    close    = in_last || (cnt_next == MAX_CNT);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_next = '0;
                    cnt_next = '0;
                    ovf_next = 1'b0;
                end
            end
            default: begin
                acc_next = '0;
                cnt_next = '0;
                ovf_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = close ? HOLD : ACCUM;
            ACCUM:   if (accept && close) state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // No skid buffer: upstream is stalled for the whole time a result is held.
    always_comb begin
        in_ready = (state_reg != HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            out_trunc <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_next;
            ovf_reg <= ovf_next;
            if (accept && close) begin
                out_sum   <= acc_next;
                out_count <= cnt_next;
                out_ovf   <= ovf_next;
                out_trunc <= !in_last;
                out_valid <= 1'b1;
            end else if (state_reg == HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inner_prod_accum.sv
// Scoreboard bench for inner_prod_accum: stimulus pushes frame results computed from plain
// arithmetic, a monitor pops and compares on every result handshake.
module tb_inner_prod_accum;

    localparam int IN_W      = 17;
    localparam int ACC_W     = 17;
    localparam int MAX_BEATS = 4;
    localparam int CNT_W     = 3;
    localparam longint MAXV  = (64'd1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [IN_W-1:0]  in_p = '0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;
    logic             out_trunc;
    logic             out_valid;
    logic             out_ready;

    logic rand_mode = 1'b0;
    logic rand_bit = 1'b1;
    logic ready_force = 1'b1;
    assign out_ready = rand_mode ? rand_bit : ready_force;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint sum;
        longint cnt;
        bit     ovf;
        bit     trunc;
    } exp_t;

    exp_t sb[$];

    inner_prod_accum #(
        .IN_W(IN_W), .ACC_W(ACC_W), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_p(in_p), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf),
        .out_trunc(out_trunc), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1 rand_bit = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: the frame sum is just the arithmetic total of its beats.
    function automatic exp_t model(input int unsigned beats[$], input bit last);
        exp_t e;
        longint s = 0;
        foreach (beats[i]) s += longint'(beats[i]);
        e.ovf = (s > MAXV);
`ifdef INNER_PROD_ACC_SAT_EN
        e.sum = e.ovf ? MAXV : s;
`else
        e.sum = s % (MAXV + 1);
`endif
        e.cnt   = beats.size();
        e.trunc = (beats.size() == MAX_BEATS) && !last;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the beat was taken.
    task automatic send_beat(input int unsigned p, input bit last, output int waits);
        waits    = 0;
        in_p     = IN_W'(p);
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int unsigned beats[$], input bit last, input bit gaps);
        int w;
        sb.push_back(model(beats, last));
        foreach (beats[i]) begin
            if (gaps) begin
                in_last = $urandom_range(0, 1) != 0;   // in_last without in_valid must be ignored
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1 in_last = 1'b0;
            end
            send_beat(beats[i], last && (i == beats.size() - 1), w);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("result sum=%0d count=%0d ovf=%0d trunc=%0d", out_sum, out_count, out_ovf, out_trunc);
                chk("out_sum", longint'(out_sum), e.sum);
                chk("out_count", longint'(out_count), e.cnt);
                chk("out_ovf", longint'(out_ovf), longint'(e.ovf));
                chk("out_trunc", longint'(out_trunc), longint'(e.trunc));
            end
        end
    end

    initial begin
        int unsigned beats[$];
        int w;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_ovf_trunc", {out_ovf, out_trunc}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("in_ready_after_reset", in_ready, 1);

        // Reset mid-ACCUM discards the partial sum
        send_beat(100, 1'b0, w);
        send_beat(200, 1'b0, w);
        #1 rst_n = 1'b0;
        #1;
        chk("midframe_rst_valid", out_valid, 0);
        chk("midframe_rst_count", out_count, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        beats = '{5};
        send_frame(beats, 1'b1, 1'b0);
        drain();

        // Three-beat frame, latency and single-cycle valid
        sb.push_back(model('{1000, 2000, 3000}, 1'b1));
        send_beat(1000, 1'b0, w);
        send_beat(2000, 1'b0, w);
        send_beat(3000, 1'b1, w);
        @(negedge clk) chk("latency_valid", out_valid, 1);
        @(negedge clk) chk("valid_drops", out_valid, 0);
        drain();
        @(posedge clk);
        #1;

        // Backpressure: upstream holds beat 9 while the result is stalled
        ready_force = 1'b0;
        beats = '{7};
        send_frame(beats, 1'b1, 1'b0);
        in_p = IN_W'(9);
        in_last = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_sum", out_sum, 7);
            chk("bp_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1 ready_force = 1'b1;
        sb.push_back(model('{9}, 1'b1));
        send_beat(9, 1'b1, w);
        chk("bp_accept_wait", w, 1);
        drain();

        // Reset while a result is held discards it immediately
        ready_force = 1'b0;
        send_beat(50, 1'b1, w);
        @(negedge clk) chk("hold_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("hold_rst_valid", out_valid, 0);
        chk("hold_rst_sum", out_sum, 0);
        @(negedge clk) begin
            rst_n = 1'b1;
            ready_force = 1'b1;
        end
        @(posedge clk);
        #1;

        // Forced close by MAX_BEATS, then overflow
        beats = '{1, 1, 1, 1};
        send_frame(beats, 1'b0, 1'b0);
        beats = '{131071, 2};
        send_frame(beats, 1'b1, 1'b0);
        drain();

        // Random frames with random result stalls
        rand_mode = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int n;
            bit last;
            n = $urandom_range(1, MAX_BEATS);
            last = (n < MAX_BEATS) ? 1'b1 : ($urandom_range(0, 1) != 0);
            beats.delete();
            for (int b = 0; b < n; b++)
                beats.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(0, 131071) : $urandom_range(0, 40000));
            send_frame(beats, last, 1'b1);
        end
        rand_mode = 1'b0;
        drain();
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1, "timeout");
    end

endmodule
